// File: rtl/pipe_pkg.sv
// Shared encodings and widths for the pipeline hazard controller.
package pipe_pkg;

   localparam int REG_W  = 5;
   localparam int ADDR_W = 64;
   localparam int CNT_W  = 16;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Encoding 3 is unused and is decoded as RUN wherever state is interpreted.
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-status inputs and pipeline-register control outputs of the hazard controller.
interface hazard_ctrl_if;
   import pipe_pkg::*;

   logic              idex_mem_read;
   logic [REG_W-1:0]  idex_rd;
   logic              idex_valid;
   logic [REG_W-1:0]  ifid_rs1;
   logic [REG_W-1:0]  ifid_rs2;
   logic              ifid_use_rs1;
   logic              ifid_use_rs2;
   logic              ifid_valid;
   logic              ex_branch_taken;
   logic [ADDR_W-1:0] ex_target;
   logic              dmem_busy;

   logic              pc_write;
   logic              pc_sel;
   logic [ADDR_W-1:0] pc_target;
   logic              ifid_write;
   logic              ifid_flush;
   logic              idex_write;
   logic              idex_bubble;
   logic              exmem_write;

   modport master (
      input  idex_mem_read, idex_rd, idex_valid,
      input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2, ifid_valid,
      input  ex_branch_taken, ex_target, dmem_busy,
      output pc_write, pc_sel, pc_target, ifid_write, ifid_flush,
      output idex_write, idex_bubble, exmem_write
   );

   modport slave (
      output idex_mem_read, idex_rd, idex_valid,
      output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2, ifid_valid,
      output ex_branch_taken, ex_target, dmem_busy,
      input  pc_write, pc_sel, pc_target, ifid_write, ifid_flush,
      input  idex_write, idex_bubble, exmem_write
   );

endinterface

// File: rtl/lu_detect.sv
// Load-use compare: a load in EX whose destination is read by the instruction in ID.
module lu_detect
   import pipe_pkg::*;
(
   input  logic             idex_valid_i,
   input  logic             idex_mem_read_i,
   input  logic [REG_W-1:0] idex_rd_i,
   input  logic             ifid_valid_i,
   input  logic [REG_W-1:0] ifid_rs1_i,
   input  logic [REG_W-1:0] ifid_rs2_i,
   input  logic             ifid_use_rs1_i,
   input  logic             ifid_use_rs2_i,
   output logic             lu_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = ifid_use_rs1_i & (ifid_rs1_i == idex_rd_i);
   assign rs2_hit = ifid_use_rs2_i & (ifid_rs2_i == idex_rd_i);

   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   assign lu_o = idex_valid_i & idex_mem_read_i & (idex_rd_i != '0) &
                 ifid_valid_i & (rs1_hit | rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stall, taken-branch flush, load-use bubble,
// plus saturating stall/flush event counters.
module hazard_ctrl
   import pipe_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   hazard_ctrl_if.master    hz,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   state_e           state_q, state_d, state_eff;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             lu_raw;
   logic             ev_busy, ev_branch, ev_lu;

   lu_detect u_lu_detect (
      .idex_valid_i    (hz.idex_valid),
      .idex_mem_read_i (hz.idex_mem_read),
      .idex_rd_i       (hz.idex_rd),
      .ifid_valid_i    (hz.ifid_valid),
      .ifid_rs1_i      (hz.ifid_rs1),
      .ifid_rs2_i      (hz.ifid_rs2),
      .ifid_use_rs1_i  (hz.ifid_use_rs1),
      .ifid_use_rs2_i  (hz.ifid_use_rs2),
      .lu_o            (lu_raw)
   );

   always_comb begin
      state_eff = ST_RUN;
      case (state_q)
         ST_MEM_WAIT: state_eff = ST_MEM_WAIT;
         ST_FLUSH:    state_eff = ST_FLUSH;
         default:     state_eff = ST_RUN;
      endcase
   end

   // In FLUSH both EX and ID hold bubbles, so branch and load-use are meaningless.
   // MEM_WAIT with memory ready is indistinguishable from RUN.
   assign ev_busy   = hz.dmem_busy;
   assign ev_branch = ~hz.dmem_busy & hz.ex_branch_taken & (state_eff != ST_FLUSH);
   assign ev_lu     = ~hz.dmem_busy & ~hz.ex_branch_taken & lu_raw & (state_eff != ST_FLUSH);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   always_comb begin
      state_d = ST_RUN;
      if (ev_busy) begin
         state_d = ST_MEM_WAIT;
      end else if (ev_branch) begin
         state_d = ST_FLUSH;
      end
      stall_d = hz.pc_write   ? stall_q : sat_inc(stall_q);
      flush_d = hz.ifid_flush ? sat_inc(flush_q) : flush_q;
   end

   always_comb begin
      hz.pc_write    = 1'b1;
      hz.pc_sel      = 1'b0;
      hz.pc_target   = hz.ex_target;
      hz.ifid_write  = 1'b1;
      hz.ifid_flush  = 1'b0;
      hz.idex_write  = 1'b1;
      hz.idex_bubble = 1'b0;
      hz.exmem_write = 1'b1;
      // While in reset keep registers loading, but load a bubble so no X reaches EX.
      if (!reset) begin
         hz.idex_bubble = 1'b1;
      end else if (ev_busy) begin
         hz.pc_write    = 1'b0;
         hz.ifid_write  = 1'b0;
         hz.idex_write  = 1'b0;
         hz.exmem_write = 1'b0;
      end else if (ev_branch) begin
         hz.pc_sel      = 1'b1;
         hz.ifid_flush  = 1'b1;
         hz.idex_bubble = 1'b1;
      end else if (ev_lu) begin
         hz.pc_write    = 1'b0;
         hz.ifid_write  = 1'b0;
         hz.idex_bubble = 1'b1;
      end
   end

   assign state     = state_q;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  state;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   always #5 clk = ~clk;

   hazard_ctrl_if hz();

   hazard_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .hz        (hz),
      .state     (state),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   int checks = 0;
   int errors = 0;
   int mstate = 0;   // 0 run, 1 waiting on memory, 2 recovering from flush
   int mstall = 0;
   int mflush = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic busy, input logic br, input logic [63:0] tgt,
                         input logic mr, input logic [4:0] rd, input logic iv,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic fv);
      hz.dmem_busy       = busy;
      hz.ex_branch_taken = br;
      hz.ex_target       = tgt;
      hz.idex_mem_read   = mr;
      hz.idex_rd         = rd;
      hz.idex_valid      = iv;
      hz.ifid_rs1        = rs1;
      hz.ifid_rs2        = rs2;
      hz.ifid_use_rs1    = u1;
      hz.ifid_use_rs2    = u2;
      hz.ifid_valid      = fv;
   endtask

   task automatic set_idle();
      set_in(0, 0, 64'h0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0);
   endtask

   // One clock with reset high: check outputs against the rules, then advance the model.
   task automatic step();
      bit dep, stalled, redirect, hold, e_pcw, e_ifw, e_idw, e_exw, e_bub;
      dep = hz.idex_valid && hz.idex_mem_read && hz.idex_rd != 0 && hz.ifid_valid &&
            ((hz.ifid_use_rs1 && hz.ifid_rs1 == hz.idex_rd) ||
             (hz.ifid_use_rs2 && hz.ifid_rs2 == hz.idex_rd));
      hold     = hz.dmem_busy;
      redirect = !hold && hz.ex_branch_taken && mstate != 2;
      stalled  = !hold && !redirect && dep && mstate != 2;
      e_pcw = !(hold || stalled);
      e_ifw = !(hold || stalled);
      e_idw = !hold;
      e_exw = !hold;
      e_bub = redirect || stalled;
      #1;
      chk("state",       64'(state), 64'(mstate));
      chk("stall_cnt",   64'(stall_cnt), 64'(mstall));
      chk("flush_cnt",   64'(flush_cnt), 64'(mflush));
      chk("pc_write",    64'(hz.pc_write), 64'(e_pcw));
      chk("ifid_write",  64'(hz.ifid_write), 64'(e_ifw));
      chk("idex_write",  64'(hz.idex_write), 64'(e_idw));
      chk("exmem_write", 64'(hz.exmem_write), 64'(e_exw));
      chk("pc_sel",      64'(hz.pc_sel), 64'(redirect));
      chk("ifid_flush",  64'(hz.ifid_flush), 64'(redirect));
      chk("idex_bubble", 64'(hz.idex_bubble), 64'(e_bub));
      chk("pc_target",   hz.pc_target, hz.ex_target);
      @(posedge clk);
      if (!e_pcw && mstall < 65535) mstall++;
      if (redirect && mflush < 65535) mflush++;
      mstate = hold ? 1 : (redirect ? 2 : 0);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_state"},  64'(state), 64'd0);
      chk({tag, "_stall"},  64'(stall_cnt), 64'd0);
      chk({tag, "_flush"},  64'(flush_cnt), 64'd0);
      chk({tag, "_pcw"},    64'(hz.pc_write), 64'd1);
      chk({tag, "_ifw"},    64'(hz.ifid_write), 64'd1);
      chk({tag, "_idw"},    64'(hz.idex_write), 64'd1);
      chk({tag, "_exw"},    64'(hz.exmem_write), 64'd1);
      chk({tag, "_pcsel"},  64'(hz.pc_sel), 64'd0);
      chk({tag, "_iflush"}, 64'(hz.ifid_flush), 64'd0);
      chk({tag, "_bubble"}, 64'(hz.idex_bubble), 64'd1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check_reset_outputs("rst");
      mstate = 0;
      mstall = 0;
      mflush = 0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      set_idle();
      @(negedge clk);
      do_reset();

      // lw x5 in EX, consumer reads x5
      set_in(0, 0, 64'h0, 1, 5'd5, 1, 5'd5, 5'd0, 1, 0, 1);
      #1;
      chk("lu_pcw", 64'(hz.pc_write), 64'd0);
      chk("lu_bubble", 64'(hz.idex_bubble), 64'd1);
      step();
      chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
      set_idle();
      step();

      // load into x0 never stalls
      set_in(0, 0, 64'h0, 1, 5'd0, 1, 5'd0, 5'd0, 1, 1, 1);
      step();
      chk("x0_stall_cnt", 64'(stall_cnt), 64'd1);

      // taken branch, then matching load-use is suppressed in FLUSH
      do_reset();
      set_in(0, 1, 64'h100, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0);
      #1;
      chk("br_target", hz.pc_target, 64'h100);
      chk("br_pcsel", 64'(hz.pc_sel), 64'd1);
      step();
      chk("br_state", 64'(state), 64'd2);
      chk("br_flush_cnt", 64'(flush_cnt), 64'd1);
      set_in(0, 1, 64'h200, 1, 5'd7, 1, 5'd7, 5'd7, 1, 1, 1);
      #1;
      chk("flush_lu_pcw", 64'(hz.pc_write), 64'd1);
      chk("flush_lu_bubble", 64'(hz.idex_bubble), 64'd0);
      step();
      chk("after_flush_state", 64'(state), 64'd0);

      // three busy cycles with branch and load-use pending, then branch honoured
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 1, 64'h40, 1, 5'd3, 1, 5'd3, 5'd0, 1, 0, 1);
         step();
         chk("busy_state", 64'(state), 64'd1);
      end
      chk("busy_stall_cnt", 64'(stall_cnt), 64'd3);
      set_in(0, 1, 64'h40, 1, 5'd3, 1, 5'd3, 5'd0, 1, 0, 1);
      #1;
      chk("busy_then_br", 64'(hz.pc_sel), 64'd1);
      step();
      chk("busy_then_br_state", 64'(state), 64'd2);
      chk("busy_then_br_stall", 64'(stall_cnt), 64'd3);

      // reset asserted mid MEM_WAIT
      set_in(1, 0, 64'h0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0);
      step();
      step();
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("mid_wait");
      mstate = 0;
      mstall = 0;
      mflush = 0;
      @(negedge clk);
      reset = 1'b1;
      set_idle();
      step();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         set_in(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                {$urandom, $urandom},
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         step();
      end

      // saturation
      do_reset();
      set_in(1, 0, 64'h0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0);
      for (int i = 0; i < 70000; i++) begin
         @(posedge clk);
         if (mstall < 65535) mstall++;
      end
      mstate = 1;
      @(negedge clk);
      chk("sat_stall", 64'(stall_cnt), 64'hFFFF);
      step();
      chk("sat_hold", 64'(stall_cnt), 64'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock; reset  in  1  asynchronous, active-low reset.
REQ-002 SHALL have inputs: idex_mem_read 1 (load in EX); idex_rd 5; idex_valid 1.
REQ-003 SHALL have inputs: ifid_rs1 5; ifid_rs2 5; ifid_use_rs1 1; ifid_use_rs2 1; ifid_valid 1.
REQ-004 SHALL have inputs: ex_branch_taken 1 (branch/jump resolved taken in EX); ex_target 64; dmem_busy 1 (data memory not ready).
REQ-005 SHALL have outputs: pc_write 1; pc_sel 1 (1 = load ex_target); pc_target 64; ifid_write 1; ifid_flush 1; idex_write 1; idex_bubble 1 (load zero controls, instr_valid=0); exmem_write 1.
REQ-006 SHALL have outputs: state 2 (debug); stall_cnt 16; flush_cnt 16.

Function
REQ-007 States: RUN=0, MEM_WAIT=1, FLUSH=2; encoding 3 unused, decodes as RUN.
REQ-008 Load-use hazard (lu) = idex_valid & idex_mem_read & idex_rd!=0 & ifid_valid & ((ifid_use_rs1 & rs1==idex_rd) | (ifid_use_rs2 & rs2==idex_rd)).
REQ-009 Event priority, highest first: dmem_busy, ex_branch_taken, lu.
REQ-010 Outputs combinational from state and inputs; default all *_write=1, pc_sel=0, flushes/bubble=0, pc_target=ex_target always.
REQ-011 RUN, dmem_busy=1: pc_write=ifid_write=idex_write=exmem_write=0; next MEM_WAIT; branch and lu ignored that cycle.
REQ-012 MEM_WAIT: all four writes 0 while dmem_busy=1; on dmem_busy=0 behave as RUN same cycle and follow RUN transitions.
REQ-013 RUN, ex_branch_taken=1 (dmem_busy=0): pc_sel=1, ifid_flush=1, idex_bubble=1; next FLUSH.
REQ-014 FLUSH: lu forced 0 (IF/ID holds bubble); dmem_busy -> MEM_WAIT per REQ-011; ex_branch_taken ignored (EX holds bubble); else next RUN.
REQ-015 RUN, lu=1 only: pc_write=0, ifid_write=0, idex_bubble=1; state stays RUN; exactly one bubble per load-use pair.
REQ-016 stall_cnt +1 each cycle with pc_write=0; flush_cnt +1 each cycle with ifid_flush=1; both saturate at 16'hFFFF.
REQ-017 idex_bubble and idex_write=0 never asserted together; ifid_flush and ifid_write=0 never together.

Reset
REQ-018 reset=0 asynchronously forces state=RUN, stall_cnt=0, flush_cnt=0.
REQ-019 During reset, outputs SHALL be: writes=1, pc_sel=0, ifid_flush=0, idex_bubble=1 (no X injected into ID/EX).
REQ-020 Reset mid-MEM_WAIT or mid-FLUSH SHALL abandon the operation; first cycle after release is RUN.

Structure
REQ-021 State encodings and counter width (16) SHALL live in shared package pipe_pkg.
REQ-022 Load-use compare SHALL be sub-module lu_detect (pure combinational); FSM and counters in hazard_ctrl.
REQ-023 Target 120-250 lines RTL; no latches; single always block for sequential state.

Verification
REQ-024 lw x5 in EX (idex_rd=5, mem_read=1), ifid_rs1=5 use=1 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt 0->1.
REQ-025 idex_rd=0 with mem_read=1, rs1=0 -> no stall; all writes 1.
REQ-026 ex_branch_taken=1, ex_target=0x100 -> pc_sel=1, pc_target=0x100, ifid_flush=1, idex_bubble=1; next cycle state=FLUSH, lu suppressed even if matching; flush_cnt=1.
REQ-027 dmem_busy=1 for 3 cycles with simultaneous branch and lu -> all writes 0 for 3 cycles, state=MEM_WAIT; 4th cycle branch honoured; stall_cnt=3.
REQ-028 reset pulled low during MEM_WAIT -> state=RUN, counters 0 immediately, idex_bubble=1 while low.
REQ-029 Force 70000 stall cycles -> stall_cnt holds 16'hFFFF, no wrap.
